// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues word reads to instruction memory and holds one
// fetched instruction (with its PC+4) for the IF/ID register until consumed.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] addr_q;
  logic [31:0] br_target;
  logic [31:0] pc_plus4;

  assign br_target = branch_addr & 32'hFFFF_FFFC;
  assign pc_plus4  = pc + 32'd4;

  // DRAIN keeps presenting the stale address until the uncancellable read acks.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? addr_q : pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC & 32'hFFFF_FFFC;
      addr_q      <= '0;
      PC          <= '0;
      Instruction <= '0;
      valid       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (branch_taken) pc <= br_target;
          state <= FETCH;
        end

        FETCH: begin
          addr_q <= pc;
          if (imem_ack) begin
            if (branch_taken) begin
              pc <= br_target;
            end else begin
              Instruction <= imem_rdata;
              PC          <= pc_plus4;
              pc          <= pc_plus4;
              valid       <= 1'b1;
              state       <= HOLD;
            end
          end else if (branch_taken) begin
            pc    <= br_target;
            state <= DRAIN;
          end
        end

        DRAIN: begin
          if (branch_taken) pc <= br_target;
          if (imem_ack) state <= FETCH;
        end

        HOLD: begin
          if (branch_taken) pc <= br_target;
          if (branch_taken || !freeze) begin
            valid       <= 1'b0;
            Instruction <= '0;
            PC          <= '0;
            state       <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, fetch/hold/freeze, redirects, wrap, mid-read reset.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        valid;

  int checks = 0;
  int errors = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(PC),
    .Instruction(Instruction), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full output snapshot: req, addr (only when req expected), valid, PC, Instruction.
  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] pcv, input logic [31:0] ins);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, vld});
    chk({tag, ".PC"}, PC, pcv);
    chk({tag, ".Instr"}, Instruction, ins);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    #2;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    chk_all("idle_after_release", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // First fetch at RESET_PC, one-cycle ack
    step();
    chk_all("first_fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hE3A0_0001;
    step();
    imem_ack = 1'b0;
    chk_all("hold0", 1'b0, 32'h0, 1'b1, 32'h4, 32'hE3A0_0001);
    step();
    chk_all("fetch4", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    step();
    imem_ack = 1'b0; freeze = 1'b1;
    chk_all("hold4", 1'b0, 32'h0, 1'b1, 32'h8, 32'h1111_2222);

    // Freeze holds outputs for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("frozen", 1'b0, 32'h0, 1'b1, 32'h8, 32'h1111_2222);
    end
    freeze = 1'b0;
    step();
    chk_all("unfreeze", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);

    // Redirect while read outstanding (low address bits ignored)
    branch_taken = 1'b1; branch_addr = 32'h0000_0103;
    step();
    branch_taken = 1'b0;
    chk_all("drain1", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    step();
    chk_all("drain2", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk_all("after_drain", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);

    // Ack and branch together in FETCH: data dropped, refetch at target
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    branch_taken = 1'b1; branch_addr = 32'h200;
    step();
    branch_taken = 1'b0;
    chk_all("ack_branch", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
    imem_rdata = 32'h0A0B_0C0D;
    step();
    imem_ack = 1'b0;
    chk_all("hold200", 1'b0, 32'h0, 1'b1, 32'h204, 32'h0A0B_0C0D);

    // Branch wins over freeze in HOLD
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h40;
    step();
    freeze = 1'b0; branch_taken = 1'b0;
    chk_all("hold_branch", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);

    // Branch into DRAIN, then branch coinciding with drain ack
    branch_taken = 1'b1; branch_addr = 32'h500;
    step();
    chk_all("drain_b", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    branch_addr = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    step();
    branch_taken = 1'b0;
    chk_all("drain_ack_branch", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    chk_all("wrap_hold", 1'b0, 32'h0, 1'b1, 32'h0, 32'h1234_5678);
    step();
    chk_all("wrap_fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset during an outstanding read; late ack lands in IDLE
    branch_taken = 1'b1; branch_addr = 32'h80;
    step();
    branch_taken = 1'b0;
    chk_all("pre_reset_drain", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    chk_all("late_ack_idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    imem_ack = 1'b0;
    chk_all("refetch_reset_pc", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    chk_all("still_fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Branch and freeze during IDLE: branch redirects, freeze ignored
    rst = 1'b0;
    step();
    rst = 1'b1; branch_taken = 1'b1; branch_addr = 32'h300; freeze = 1'b1;
    step();
    branch_taken = 1'b0; freeze = 1'b0;
    chk_all("idle_branch", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000;
    errors++;
    $display("FAIL timeout: bench did not complete within 5000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 freeze  input  1  downstream hazard stall; held instruction is not consumed while 1.
REQ-005 branch_taken  input  1  redirect request from execute; one-cycle pulse.
REQ-006 branch_addr  input  32  redirect target; bits [1:0] ignored, treated as 00.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  word-aligned read address.
REQ-009 imem_ack  input  1  read completes in a cycle with imem_req=1 and imem_ack=1.
REQ-010 imem_rdata  input  32  read data, valid only in the ack cycle.
REQ-011 PC  output  32  address of held instruction + 4.
REQ-012 Instruction  output  32  held instruction word.
REQ-013 valid  output  1  PC/Instruction hold a real instruction for the IF/ID register.

Function
REQ-014 Internal state: fetch pointer pc (32b), hold address addr_q (32b), FSM {IDLE, FETCH, DRAIN, HOLD}.
REQ-015 Outputs PC, Instruction, valid SHALL be registered; Instruction is never driven combinationally from imem_rdata.
REQ-016 IDLE: imem_req=0; unconditionally -> FETCH next cycle.
REQ-017 FETCH: imem_req=1, imem_addr=pc; addr_q<=pc every cycle.
REQ-018 FETCH, ack=1, branch_taken=0: Instruction<=imem_rdata, PC<=pc+4, pc<=pc+4, valid<=1, -> HOLD.
REQ-019 FETCH, ack=1, branch_taken=1: data discarded, valid stays 0, pc<=branch_addr, stay FETCH; next request uses new pc the following cycle.
REQ-020 FETCH, ack=0, branch_taken=1: pc<=branch_addr, -> DRAIN (outstanding read cannot be cancelled).
REQ-021 FETCH, ack=0, branch_taken=0: hold state; imem_addr stable.
REQ-022 DRAIN: imem_req=1, imem_addr=addr_q (stale address held stable); on ack data discarded, -> FETCH; further branch_taken in DRAIN updates pc only, and if it coincides with the ack both occur.
REQ-023 HOLD: imem_req=0; valid=1 and outputs stable while freeze=1 and branch_taken=0.
REQ-024 HOLD, branch_taken=1: valid<=0, Instruction<=0, PC<=0, pc<=branch_addr, -> FETCH; branch_taken SHALL take priority over freeze.
REQ-025 HOLD, freeze=0, branch_taken=0: instruction consumed at this edge; valid<=0, -> FETCH.
REQ-026 Whenever valid=0, Instruction and PC SHALL read 0 (bubble).
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0); no carry-out.
REQ-028 valid SHALL never be asserted for data returned by a read issued before a redirect.
REQ-029 Peak throughput: one instruction per 2 cycles with single-cycle memory (FETCH+ack, HOLD consumed).
REQ-030 branch_taken and freeze in IDLE: branch updates pc; freeze has no effect.

Reset
REQ-031 While rst=0: state=IDLE, pc=RESET_PC, addr_q=0, PC=0, Instruction=0, valid=0, imem_req=0, asynchronously.
REQ-032 Reset asserted mid-read SHALL abandon the read; a late ack after release, arriving in IDLE, SHALL be ignored.
REQ-033 First imem_req SHALL assert in the second clock after rst deasserts (IDLE cycle, then FETCH).

Verification
REQ-034 Reset release, 1-cycle ack memory returning 32'hE3A0_0001 at addr 0 -> imem_addr=0, then valid=1, Instruction=32'hE3A0_0001, PC=4; next fetch addr 4.
REQ-035 valid=1, freeze=1 for 3 cycles -> outputs unchanged, imem_req=0; freeze drops -> valid=0 next cycle, imem_addr=8.
REQ-036 Memory ack delayed 3 cycles, branch_taken=1 to 32'h100 in cycle 1 -> imem_addr holds old value until ack, data dropped, next request addr 32'h100, valid never asserted for old data.
REQ-037 HOLD with freeze=1 and branch_taken=1 to 32'h40 same cycle -> valid=0, Instruction=0, next imem_addr=32'h40.
REQ-038 Branch to 32'hFFFF_FFFC, fetch completes -> PC=0, next imem_addr=0.
REQ-039 rst pulsed low during outstanding read with ack arriving in IDLE -> valid stays 0, first fetch at RESET_PC.
